conn_win_scanner: RTL and testbench

Parametrised, sequential successor to the single-cycle Connect-4 winner check. It snapshots the game board on a `start` pulse and scans one anchor cell per cycle for lines of `WIN_LEN` equal non-empty cells in four directions. It reports the winner, win or draw status, and a highlighted copy of the board. It sits between the move/turn controller and the VGA board renderer, and supports arbitrary board sizes and line lengths at a fraction of the combinational area.

---
 rtl/conn_win_scanner.sv | 183 ++++++++++++++++++
 tb/tb_conn_win_scanner.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/conn_win_scanner.sv
// Sequential Connect-N winner scanner: snapshots the board on start, checks one
// anchor cell per cycle in four directions, then reports winner/draw and a highlighted board.
module conn_win_scanner #(
  parameter int ROWS    = 6,
  parameter int COLS    = 7,
  parameter int WIN_LEN = 4,
  parameter int CELL_W  = 3,
  parameter logic [CELL_W-1:0] HL_CODE = 3'b011
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [ROWS*COLS*CELL_W-1:0]   board,
  output logic                          busy,
  output logic                          done,
  output logic                          game_over,
  output logic [CELL_W-1:0]             winner,
  output logic                          draw,
  output logic [ROWS*COLS*CELL_W-1:0]   board_out
);

  localparam int NCELL = ROWS * COLS;
  localparam int BW    = NCELL * CELL_W;
  localparam int RW    = $clog2(ROWS);
  localparam int CW    = $clog2(COLS);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t            r_state, w_next;
  logic [BW-1:0]     r_snap, r_board_out, w_board_hl;
  logic [NCELL-1:0]  r_mask, w_line_mask;
  logic              r_found, r_empty, r_done, r_game_over, r_draw;
  logic [CELL_W-1:0] r_cand, r_winner, w_anchor;
  logic [RW-1:0]     r_row;
  logic [CW-1:0]     r_col;
  logic              w_last, w_hit_any, w_start;

  function automatic logic [CELL_W-1:0] cell_at(input logic [BW-1:0] b, input int r, input int c);
    return CELL_W'(b >> ((r * COLS + c) * CELL_W));
  endfunction

  // Direction index: 0=E, 1=S, 2=SE, 3=NE (also the win priority order).
  function automatic int dir_dr(input int d);
    case (d)
      1, 2:    return 1;
      3:       return -1;
      default: return 0;
    endcase
  endfunction

  function automatic int dir_dc(input int d);
    return (d == 1) ? 0 : 1;
  endfunction

  function automatic logic line_hit(input logic [BW-1:0] b, input int r, input int c,
                                    input int dr, input int dc);
    logic [CELL_W-1:0] a;
    logic              hit;
    int                er, ec;
    a   = cell_at(b, r, c);
    er  = r + dr * (WIN_LEN - 1);
    ec  = c + dc * (WIN_LEN - 1);
    hit = (a != '0) && (er >= 0) && (er < ROWS) && (ec >= 0) && (ec < COLS);
    if (hit) begin
      for (int unsigned k = 1; k < WIN_LEN; k++) begin
        if (cell_at(b, r + dr * int'(k), c + dc * int'(k)) != a) hit = 1'b0;
      end
    end
    return hit;
  endfunction

  assign w_start = start && (r_state == IDLE) && !r_done;
  assign w_last  = (r_row == RW'(ROWS - 1)) && (r_col == CW'(COLS - 1));

  // All hits in one cycle share the anchor value, so one mask covers them all.
  always_comb begin
    w_anchor    = cell_at(r_snap, int'(r_row), int'(r_col));
    w_hit_any   = 1'b0;
    w_line_mask = '0;
    for (int unsigned d = 0; d < 4; d++) begin
      if (line_hit(r_snap, int'(r_row), int'(r_col), dir_dr(int'(d)), dir_dc(int'(d)))) begin
        w_hit_any = 1'b1;
        for (int unsigned k = 0; k < WIN_LEN; k++) begin
          w_line_mask = w_line_mask | (NCELL'(1) << ((int'(r_row) + dir_dr(int'(d)) * int'(k)) * COLS
                                                     + int'(r_col) + dir_dc(int'(d)) * int'(k)));
        end
      end
    end
  end

  always_comb begin
    w_board_hl = r_snap;
    for (int unsigned i = 0; i < NCELL; i++) begin
      if (1'(r_mask >> i)) begin
        w_board_hl = (w_board_hl & ~(BW'({CELL_W{1'b1}}) << (i * CELL_W)))
                   | (BW'(HL_CODE) << (i * CELL_W));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_next = SCAN;
      SCAN:    if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // done is registered out of DONE, so busy stays up through the done cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_snap      <= '0;
      r_mask      <= '0;
      r_found     <= 1'b0;
      r_empty     <= 1'b0;
      r_cand      <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_done      <= 1'b0;
      r_game_over <= 1'b0;
      r_winner    <= '0;
      r_draw      <= 1'b0;
      r_board_out <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_snap      <= board;
            r_mask      <= '0;
            r_found     <= 1'b0;
            r_empty     <= 1'b0;
            r_cand      <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_game_over <= 1'b0;
            r_winner    <= '0;
            r_draw      <= 1'b0;
          end
        end
        SCAN: begin
          if (w_anchor == '0) r_empty <= 1'b1;
          if (w_hit_any && (!r_found || (w_anchor == r_cand))) begin
            r_mask  <= r_mask | w_line_mask;
            r_found <= 1'b1;
            r_cand  <= w_anchor;
          end
          if (!w_last) begin
            if (r_col == CW'(COLS - 1)) begin
              r_col <= '0;
              r_row <= r_row + RW'(1);
            end else begin
              r_col <= r_col + CW'(1);
            end
          end
        end
        DONE: begin
          r_board_out <= w_board_hl;
          r_winner    <= r_found ? r_cand : '0;
          r_draw      <= !r_found && !r_empty;
          r_game_over <= r_found || !r_empty;
          r_done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (r_state != IDLE) || r_done;
  assign done      = r_done;
  assign game_over = r_game_over;
  assign winner    = r_winner;
  assign draw      = r_draw;
  assign board_out = r_board_out;

endmodule

// File: tb/tb_conn_win_scanner.sv
// Randomized and directed checks of conn_win_scanner (6x7x4 and 8x8x5) against
// a line-enumerating reference model of the board.
module tb_conn_win_scanner;

  localparam int AR = 6, AC = 7, AL = 4;
  localparam int BR = 8, BC = 8, BL = 5;
  localparam int AB = AR * AC * 3;
  localparam int BB = BR * BC * 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          start_a, busy_a, done_a, go_a, draw_a;
  logic [2:0]    win_a;
  logic [AB-1:0] board_a, bout_a;
  logic          start_b, busy_b, done_b, go_b, draw_b;
  logic [2:0]    win_b;
  logic [BB-1:0] board_b, bout_b;

  conn_win_scanner u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .board(board_a), .busy(busy_a), .done(done_a),
    .game_over(go_a), .winner(win_a), .draw(draw_a), .board_out(bout_a));

  conn_win_scanner #(.ROWS(BR), .COLS(BC), .WIN_LEN(BL), .CELL_W(3), .HL_CODE(3'b011)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .board(board_b), .busy(busy_b), .done(done_b),
    .game_over(go_b), .winner(win_b), .draw(draw_b), .board_out(bout_b));

  int sel;
  logic         m_busy, m_done, m_go, m_draw;
  logic [2:0]   m_win;
  logic [191:0] m_bout;
  assign m_busy = (sel != 0) ? busy_b : busy_a;
  assign m_done = (sel != 0) ? done_b : done_a;
  assign m_go   = (sel != 0) ? go_b   : go_a;
  assign m_draw = (sel != 0) ? draw_b : draw_a;
  assign m_win  = (sel != 0) ? win_b  : win_a;
  assign m_bout = (sel != 0) ? bout_b : 192'(bout_a);

  int n_vec = 0;
  int n_bad = 0;
  int g[8][8];

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_grid();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) g[r][c] = 0;
  endtask

  function automatic logic [191:0] pack(input int R, input int C);
    logic [191:0] v = '0;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) v = v | (192'(g[r][c] & 7) << ((r * C + c) * 3));
    return v;
  endfunction

  // Enumerate every in-bounds line in raster/priority order; the first one fixes the winner.
  task automatic model(input int R, input int C, input int L,
                       output int win, output bit drw, output logic [191:0] bo);
    int dr[4] = '{0, 1, 1, -1};
    int dc[4] = '{1, 0, 1, 1};
    bit hl[8][8];
    bit emp, ok;
    int er, ec, v;
    win = 0; emp = 0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) hl[r][c] = 0;
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) begin
        if (g[r][c] == 0) emp = 1;
        for (int d = 0; d < 4; d++) begin
          er = r + dr[d] * (L - 1);
          ec = c + dc[d] * (L - 1);
          if (g[r][c] == 0 || er < 0 || er >= R || ec < 0 || ec >= C) continue;
          ok = 1;
          for (int k = 1; k < L; k++)
            if (g[r + dr[d] * k][c + dc[d] * k] != g[r][c]) ok = 0;
          if (!ok) continue;
          if (win == 0) win = g[r][c];
          if (g[r][c] == win)
            for (int k = 0; k < L; k++) hl[r + dr[d] * k][c + dc[d] * k] = 1;
        end
      end
    end
    drw = (win == 0) && !emp;
    bo = '0;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) begin
        v = hl[r][c] ? 3 : g[r][c];
        bo = bo | (192'(v & 7) << ((r * C + c) * 3));
      end
  endtask

  task automatic drive(input bit s, input logic [191:0] b);
    if (sel != 0) begin start_b = s; board_b = BB'(b); end
    else          begin start_a = s; board_a = AB'(b); end
  endtask

  task automatic scan(input bit mid_start, input bit hold_chk);
    int R, C, L, win, lat, ndone;
    bit drw, seen;
    logic [191:0] bo, bin;
    R = (sel != 0) ? BR : AR;
    C = (sel != 0) ? BC : AC;
    L = (sel != 0) ? BL : AL;
    model(R, C, L, win, drw, bo);
    bin = pack(R, C);
    @(negedge clk); drive(1'b1, bin);
    @(negedge clk); drive(1'b0, bin);
    check("busy_after_start", m_busy, 1);
    check("winner_cleared", m_win, 0);
    check("game_over_cleared", m_go, 0);
    seen = 0;
    for (lat = 1; lat <= 200; lat++) begin
      @(posedge clk); #1;
      if (lat == 5)  drive(1'b0, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      if (mid_start && lat == 10) drive(1'b1, bin);
      if (mid_start && lat == 11) drive(1'b0, bin);
      if (m_done) begin seen = 1; break; end
    end
    check("done_seen", seen, 1);
    if (!seen) return;
    check("latency", lat, R * C + 1);
    check("busy_in_done", m_busy, 1);
    check("winner", m_win, win);
    check("draw", m_draw, drw);
    check("game_over", m_go, (win != 0) || drw);
    check("board_out", m_bout, bo);
    @(posedge clk); #1;
    check("done_one_cycle", m_done, 0);
    if (mid_start) begin
      ndone = 0;
      repeat (50) begin @(posedge clk); #1; if (m_done) ndone++; end
      check("no_extra_done", ndone, 0);
    end
    if (hold_chk) begin
      repeat (4) @(posedge clk);
      #1;
      check("hold_board_out", m_bout, bo);
      check("hold_winner", m_win, win);
    end
  endtask

  task automatic rand_grid(input int R, input int C, input int fill_pct, input int players);
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        g[r][c] = ($urandom_range(0, 99) < fill_pct) ? int'($urandom_range(1, players)) : 0;
  endtask

  initial begin
    int ndone;
    sel = 0;
    rst = 1'b1;
    start_a = 1'b0; board_a = '0;
    start_b = 1'b0; board_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_game_over", go_a, 0);
    check("rst_winner", win_a, 0);
    check("rst_draw", draw_a, 0);
    check("rst_board_out", bout_a, 0);
    @(negedge clk); rst = 1'b0;

    // empty board
    clear_grid(); scan(1'b0, 1'b1);
    // bottom row, four of player 1
    clear_grid(); for (int c = 0; c < 4; c++) g[5][c] = 1; scan(1'b0, 1'b1);
    // NE diagonal of 2 plus vertical of 1 in column 6
    clear_grid();
    for (int k = 0; k < 4; k++) begin g[5 - k][k] = 2; g[2 + k][6] = 1; end
    scan(1'b0, 1'b0);
    // full board, no line
    for (int r = 0; r < AR; r++)
      for (int c = 0; c < AC; c++) g[r][c] = 1 + ((r / 2 + c) % 2);
    scan(1'b0, 1'b1);
    // start dropped mid-scan
    rand_grid(AR, AC, 70, 2); scan(1'b1, 1'b0);

    // reset mid-scan
    rand_grid(AR, AC, 70, 2);
    @(negedge clk); drive(1'b1, pack(AR, AC));
    @(negedge clk); drive(1'b0, pack(AR, AC));
    repeat (19) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midrst_busy", busy_a, 0);
    check("midrst_done", done_a, 0);
    check("midrst_winner", win_a, 0);
    check("midrst_board_out", bout_a, 0);
    @(negedge clk); rst = 1'b0;
    ndone = 0;
    repeat (60) begin @(posedge clk); #1; if (done_a) ndone++; end
    check("midrst_no_done", ndone, 0);
    scan(1'b0, 1'b0);

    // randomized back-to-back scans
    for (int i = 0; i < 24; i++) begin
      if (i % 4 == 3) rand_grid(AR, AC, 100, 2);
      else            rand_grid(AR, AC, 55 + int'($urandom_range(0, 40)), 2 + (i % 3));
      scan(1'b0, 1'b0);
    end

    // 8x8, WIN_LEN=5
    sel = 1;
    clear_grid();
    for (int k = 0; k < 5; k++) g[k][k] = int'($urandom_range(1, 7));
    for (int k = 1; k < 5; k++) g[k][k] = g[0][0];
    scan(1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      rand_grid(BR, BC, 60 + int'($urandom_range(0, 40)), 2);
      scan(1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
